i2c_slave_single_byte: RTL and testbench

I2C_SLAVE_SINGLE_BYTE -- requirements
Module: i2c_slave_single_byte

---
 rtl/i2c_slave_single_byte.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_i2c_slave_single_byte.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_single_byte.sv
// ----------------------------------------------------------------------------
// i2c_slave_single_byte
//
// I2C slave that answers a single 7-bit address. A master write delivers
// bytes on o_Rx_Byte (multi-byte writes allowed). A master read returns
// i_Tx_Byte, which is fetched again after every master ACK.
// SCL is never driven, so there is no clock stretching. SDA is open-drain:
// the block drives it only to 0 or Z.
//
// Optional feature:
//   I2C_SLAVE_GLITCH_FILTER_EN - when defined, a synchronized SCL/SDA change
//   is accepted only after 3 equal consecutive samples. Shorter pulses are
//   ignored, and edges are seen 3 cycles later.
//
// Parameters:
//   SLAVE_ADDR  7-bit address this slave responds to (default 7'h51)
//
// Ports:
//   i_Clk       system clock (single clock domain)
//   i_Rst_n     asynchronous active-low reset
//   i_Enable    1 = take part in bus traffic, 0 = release SDA and stay IDLE
//   i_Tx_Byte   byte returned on a master read
//   o_Tx_Req    one-cycle pulse when i_Tx_Byte is captured
//   o_Rx_Byte   last byte written by the master
//   o_Rx_Valid  one-cycle pulse when o_Rx_Byte updates
//   o_Busy      high from address match until STOP, START or NACK
//   io_scl      I2C clock (input only)
//   io_sda      I2C data (open-drain)
// ----------------------------------------------------------------------------
module i2c_slave_single_byte #(
    parameter logic [6:0] SLAVE_ADDR = 7'h51
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Enable,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Req,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Valid,
    output logic       o_Busy,
    inout  wire        io_scl,
    inout  wire        io_sda
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    state_t     state_q, state_next;
    logic [3:0] bit_cnt_q, bit_cnt_next;
    logic [7:0] shift_q, shift_next;
    logic       rw_q, rw_next;
    logic       got_ack_q, got_ack_next;
    logic       sda_low_q, sda_low_next;
    logic       busy_q, busy_next;
    logic [7:0] rx_byte_q, rx_byte_next;
    logic       rx_valid_q, rx_valid_next;
    logic       tx_req_q, tx_req_next;

    logic scl_meta, scl_sync, sda_meta, sda_sync;
    logic scl_line, sda_line;
    logic scl_prev, sda_prev;
    logic [2:0] warm_q;

    logic bus_ok;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] byte_in;

    // The block never drives SCL.
    assign io_scl = 1'bz;
    assign io_sda = sda_low_q ? 1'b0 : 1'bz;

    // Two-flop synchronizers. They reset to 1, the idle level of the bus.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            scl_meta <= io_scl;
            scl_sync <= scl_meta;
            sda_meta <= io_sda;
            sda_sync <= sda_meta;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_cnt, sda_cnt;
    logic       scl_filt, sda_filt;

    // The filtered level follows the synchronized level only after the
    // new value has been seen on 3 consecutive cycles.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
            scl_cnt  <= 2'd0;
            sda_cnt  <= 2'd0;
        end else begin
            if (scl_sync == scl_filt) begin
                scl_cnt <= 2'd0;
            end else if (scl_cnt == 2'd2) begin
                scl_filt <= scl_sync;
                scl_cnt  <= 2'd0;
            end else begin
                scl_cnt <= scl_cnt + 2'd1;
            end
            if (sda_sync == sda_filt) begin
                sda_cnt <= 2'd0;
            end else if (sda_cnt == 2'd2) begin
                sda_filt <= sda_sync;
                sda_cnt  <= 2'd0;
            end else begin
                sda_cnt <= sda_cnt + 2'd1;
            end
        end
    end

    assign scl_line = scl_filt;
    assign sda_line = sda_filt;
`else
    assign scl_line = scl_sync;
    assign sda_line = sda_sync;
`endif

    // Keep the previous line levels for edge detection. Edges are ignored
    // for a few cycles after reset while the synchronizer pipeline fills
    // from its reset value of 1. Without this, a low SDA at reset release
    // would look like a START.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
            warm_q   <= 3'd0;
        end else begin
            scl_prev <= scl_line;
            sda_prev <= sda_line;
            if (warm_q != 3'd7) begin
                warm_q <= warm_q + 3'd1;
            end
        end
    end

    assign bus_ok    = (warm_q == 3'd7);
    assign scl_rise  = bus_ok &  scl_line & ~scl_prev;
    assign scl_fall  = bus_ok & ~scl_line &  scl_prev;
    assign start_det = bus_ok & scl_line & scl_prev &  sda_prev & ~sda_line;
    assign stop_det  = bus_ok & scl_line & scl_prev & ~sda_prev &  sda_line;
    assign byte_in   = {shift_q[6:0], sda_line};

    // State and datapath registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            got_ack_q  <= 1'b0;
            sda_low_q  <= 1'b0;
            busy_q     <= 1'b0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_next;
            bit_cnt_q  <= bit_cnt_next;
            shift_q    <= shift_next;
            rw_q       <= rw_next;
            got_ack_q  <= got_ack_next;
            sda_low_q  <= sda_low_next;
            busy_q     <= busy_next;
            rx_byte_q  <= rx_byte_next;
            rx_valid_q <= rx_valid_next;
            tx_req_q   <= tx_req_next;
        end
    end

    // Next-state logic. Disable has the highest priority, then STOP, then
    // START. An ACK state drives SDA on its first SCL fall (the 8th) and
    // releases or hands over on its second fall (the 9th). sda_low_q tells
    // the two falls apart.
    always_comb begin
        state_next    = state_q;
        bit_cnt_next  = bit_cnt_q;
        shift_next    = shift_q;
        rw_next       = rw_q;
        got_ack_next  = got_ack_q;
        sda_low_next  = sda_low_q;
        busy_next     = busy_q;
        rx_byte_next  = rx_byte_q;
        rx_valid_next = 1'b0;
        tx_req_next   = 1'b0;

        if (!i_Enable) begin
            state_next   = IDLE;
            bit_cnt_next = 4'd0;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
            got_ack_next = 1'b0;
        end else if (stop_det) begin
            state_next   = IDLE;
            bit_cnt_next = 4'd0;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
            got_ack_next = 1'b0;
        end else if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 4'd0;
            sda_low_next = 1'b0;
            busy_next    = 1'b0;
            got_ack_next = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_next = ADDR_ACK;
                                busy_next  = 1'b1;
                                rw_next    = byte_in[0];
                            end else begin
                                state_next   = WAIT_STOP;
                                sda_low_next = 1'b0;
                            end
                        end
                    end
                end

                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_next = 1'b1;
                        end else if (rw_q) begin
                            // Read: fetch the byte and put its MSB on SDA
                            // on this same falling edge.
                            shift_next   = i_Tx_Byte;
                            sda_low_next = ~i_Tx_Byte[7];
                            tx_req_next  = 1'b1;
                            bit_cnt_next = 4'd0;
                            state_next   = RD_DATA;
                        end else begin
                            sda_low_next = 1'b0;
                            bit_cnt_next = 4'd0;
                            state_next   = WR_DATA;
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift_next   = byte_in;
                        bit_cnt_next = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            rx_byte_next  = byte_in;
                            rx_valid_next = 1'b1;
                            bit_cnt_next  = 4'd0;
                            state_next    = WR_ACK;
                        end
                    end
                end

                WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_low_q) begin
                            sda_low_next = 1'b1;
                        end else begin
                            sda_low_next = 1'b0;
                            bit_cnt_next = 4'd0;
                            state_next   = WR_DATA;
                        end
                    end
                end

                RD_DATA: begin
                    // bit_cnt_q counts rising edges already sent. After the
                    // 8th rising edge, the next fall hands SDA back to the
                    // master for its ACK.
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_next = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_low_next = 1'b0;
                            bit_cnt_next = 4'd0;
                            got_ack_next = 1'b0;
                            state_next   = RD_ACK;
                        end else begin
                            shift_next   = {shift_q[6:0], 1'b0};
                            sda_low_next = ~shift_q[6];
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_line) begin
                            got_ack_next = 1'b1;
                        end else begin
                            state_next = WAIT_STOP;
                            busy_next  = 1'b0;
                        end
                    end
                    if (scl_fall && got_ack_q) begin
                        shift_next   = i_Tx_Byte;
                        sda_low_next = ~i_Tx_Byte[7];
                        tx_req_next  = 1'b1;
                        got_ack_next = 1'b0;
                        bit_cnt_next = 4'd0;
                        state_next   = RD_DATA;
                    end
                end

                WAIT_STOP: begin
                    sda_low_next = 1'b0;
                end

                default: begin
                    state_next   = IDLE;
                    sda_low_next = 1'b0;
                    busy_next    = 1'b0;
                end
            endcase
        end
    end

    assign o_Rx_Byte  = rx_byte_q;
    assign o_Rx_Valid = rx_valid_q;
    assign o_Tx_Req   = tx_req_q;
    assign o_Busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_single_byte.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_single_byte
//
// Directed testbench for i2c_slave_single_byte. A behavioural open-drain
// master bit-bangs SCL/SDA on pulled-up nets. Expected values are
// hand-computed:
//   address 0x51 write = 0xA2, read = 0xA3, address 0x52 write = 0xA4.
// ----------------------------------------------------------------------------
module tb_i2c_slave_single_byte;

    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_req;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       busy;

    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    wire  scl_bus;
    wire  sda_bus;

    int assert_count = 0;
    int fail_count   = 0;

    int rx_valid_cycles = 0;
    int tx_req_cycles   = 0;
    int busy_cycles     = 0;
    int dut_drive_cycles = 0;

    assign scl_bus = m_scl ? 1'bz : 1'b0;
    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (scl_bus);
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave_single_byte #(.SLAVE_ADDR(7'h51)) dut (
        .i_Clk      (clk),
        .i_Rst_n    (rst_n),
        .i_Enable   (enable),
        .i_Tx_Byte  (tx_byte),
        .o_Tx_Req   (tx_req),
        .o_Rx_Byte  (rx_byte),
        .o_Rx_Valid (rx_valid),
        .o_Busy     (busy),
        .io_scl     (scl_bus),
        .io_sda     (sda_bus)
    );

    // Pulse and drive monitors, sampled away from the active clock edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_valid_cycles++;
        if (tx_req === 1'b1) tx_req_cycles++;
        if (busy === 1'b1) busy_cycles++;
        if (m_sda && sda_bus === 1'b0) dut_drive_cycles++;
    end

    task automatic apply_stimulus(input logic scl, input logic sda, input int cycles);
        m_scl = scl;
        m_sda = sda;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic bus_start();
        apply_stimulus(1'b0, m_sda, Q);
        apply_stimulus(1'b0, 1'b1, Q);
        apply_stimulus(1'b1, 1'b1, Q);
        apply_stimulus(1'b1, 1'b0, Q);
    endtask

    task automatic bus_stop();
        apply_stimulus(1'b0, m_sda, Q);
        apply_stimulus(1'b0, 1'b0, Q);
        apply_stimulus(1'b1, 1'b0, Q);
        apply_stimulus(1'b1, 1'b1, 2 * Q);
    endtask

    task automatic write_bit(input logic b);
        apply_stimulus(1'b0, m_sda, Q);
        apply_stimulus(1'b0, b, Q);
        apply_stimulus(1'b1, b, 2 * Q);
    endtask

    task automatic read_bit(output logic b);
        apply_stimulus(1'b0, m_sda, Q);
        apply_stimulus(1'b0, 1'b1, Q);
        apply_stimulus(1'b1, 1'b1, Q);
        @(negedge clk);
        b = sda_bus;
        apply_stimulus(1'b1, 1'b1, Q);
    endtask

    task automatic write_byte(input logic [7:0] data, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            write_bit(data[i]);
        end
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] data);
        for (int i = 7; i >= 0; i--) begin
            read_bit(data[i]);
        end
        write_bit(ack_bit);
    endtask

    initial begin
        logic       ack;
        logic [7:0] data;
        int         base_rx, base_tx, base_busy, base_drive;

        $display("[TB] starting");

        // Reset values
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_output("reset_rx_byte", 32'(rx_byte), 32'h00);
        check_output("reset_rx_valid", 32'(rx_valid), 32'h0);
        check_output("reset_tx_req", 32'(tx_req), 32'h0);
        check_output("reset_busy", 32'(busy), 32'h0);
        check_output("reset_sda", 32'(sda_bus), 32'h1);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // A 1-cycle SDA low pulse while SCL is high must not look like a START.
        m_sda = 1'b0;
        @(posedge clk);
        m_sda = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_output("glitch_state_idle", 32'(dut.state_q), 32'd0);
        check_output("glitch_busy", 32'(busy), 32'h0);
`endif

        // Write 0x51, data 0xAC
        base_rx = rx_valid_cycles;
        bus_start();
        write_byte(8'hA2, ack);
        check_output("wr_addr_ack", 32'(ack), 32'h0);
        check_output("wr_busy_after_match", 32'(busy), 32'h1);
        write_byte(8'hAC, ack);
        check_output("wr_data_ack", 32'(ack), 32'h0);
        bus_stop();
        check_output("wr_rx_byte", 32'(rx_byte), 32'hAC);
        check_output("wr_rx_valid_pulses", 32'(rx_valid_cycles - base_rx), 32'd1);
        check_output("wr_busy_after_stop", 32'(busy), 32'h0);

        // Write to another address (0x52): the slave stays silent
        base_rx = rx_valid_cycles;
        base_busy = busy_cycles;
        base_drive = dut_drive_cycles;
        bus_start();
        write_byte(8'hA4, ack);
        check_output("other_addr_nack", 32'(ack), 32'h1);
        write_byte(8'h55, ack);
        bus_stop();
        check_output("other_sda_driven", 32'(dut_drive_cycles - base_drive), 32'd0);
        check_output("other_rx_valid", 32'(rx_valid_cycles - base_rx), 32'd0);
        check_output("other_busy", 32'(busy_cycles - base_busy), 32'd0);

        // Read 0x51 returning 0x3C, master NACK
        tx_byte = 8'h3C;
        base_tx = tx_req_cycles;
        bus_start();
        write_byte(8'hA3, ack);
        check_output("rd_addr_ack", 32'(ack), 32'h0);
        read_byte(1'b1, data);
        check_output("rd_data", 32'(data), 32'h3C);
        check_output("rd_sda_released", 32'(sda_bus), 32'h1);
        check_output("rd_busy_after_nack", 32'(busy), 32'h0);
        check_output("rd_tx_req_pulses", 32'(tx_req_cycles - base_tx), 32'd1);
        bus_stop();

        // Write 0x11, repeated START, read 0xA5 twice (ACK then NACK)
        bus_start();
        write_byte(8'hA2, ack);
        check_output("rs_wr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h11, ack);
        check_output("rs_wr_data_ack", 32'(ack), 32'h0);
        check_output("rs_rx_byte", 32'(rx_byte), 32'h11);
        tx_byte = 8'hA5;
        base_tx = tx_req_cycles;
        bus_start();
        write_byte(8'hA3, ack);
        check_output("rs_rd_addr_ack", 32'(ack), 32'h0);
        read_byte(1'b0, data);
        check_output("rs_rd_data_first", 32'(data), 32'hA5);
        read_byte(1'b1, data);
        check_output("rs_rd_data_second", 32'(data), 32'hA5);
        check_output("rs_tx_req_pulses", 32'(tx_req_cycles - base_tx), 32'd2);
        bus_stop();
        check_output("rs_busy_after_stop", 32'(busy), 32'h0);

        // Reset during the 4th data bit of a write of 0x5A (bits 0,1,0,1)
        bus_start();
        write_byte(8'hA2, ack);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b0);
        apply_stimulus(1'b0, m_sda, Q);
        apply_stimulus(1'b0, 1'b1, Q);
        apply_stimulus(1'b1, 1'b1, Q);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("midrst_rx_byte", 32'(rx_byte), 32'h00);
        check_output("midrst_busy", 32'(busy), 32'h0);
        check_output("midrst_rx_valid", 32'(rx_valid), 32'h0);
        check_output("midrst_tx_req", 32'(tx_req), 32'h0);
        check_output("midrst_sda", 32'(sda_bus), 32'h1);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, Q);
        bus_stop();
        base_rx = rx_valid_cycles;
        bus_start();
        write_byte(8'hA2, ack);
        check_output("postrst_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h5A, ack);
        check_output("postrst_data_ack", 32'(ack), 32'h0);
        bus_stop();
        check_output("postrst_rx_byte", 32'(rx_byte), 32'h5A);
        check_output("postrst_rx_valid_pulses", 32'(rx_valid_cycles - base_rx), 32'd1);

        // Drop i_Enable while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            write_bit(i == 0 ? 1'b0 : ((8'hA2 >> i) & 8'h01) != 8'h00);
        end
        apply_stimulus(1'b0, m_sda, Q);
        apply_stimulus(1'b0, 1'b1, Q);
        @(negedge clk);
        check_output("en_ack_driven", 32'(sda_bus), 32'h0);
        check_output("en_busy_before", 32'(busy), 32'h1);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("en_sda_released", 32'(sda_bus), 32'h1);
        check_output("en_busy_after", 32'(busy), 32'h0);
        enable = 1'b1;
        apply_stimulus(1'b1, 1'b1, Q);
        bus_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
